// File: rtl/dif_mod_router.sv
// Write-side router for the two difficulty-mode registers: writes go to the
// register chosen by difMod, and a debounced-elsewhere button toggles difMod.
module dif_mod_router #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT1 = '0,
    parameter logic [WIDTH-1:0] INIT2 = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             modeBtn,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             wrValid,
    output logic             wrReady,
    output logic             wrDone,
    output logic             modeChg,
    output logic             difMod,
    output logic [WIDTH-1:0] Mod1,
    output logic [WIDTH-1:0] Mod2
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic btn_prev_reg;
    logic pend_tgl_reg, pend_tgl_next;
    logic dif_mod_reg, dif_mod_next;
    logic mod_chg_reg, mod_chg_next;
    logic wr_ready_reg, wr_ready_next;
    logic wr_done_reg, wr_done_next;
    logic rise, xfer, tgl;

    logic [WIDTH-1:0] mod_q [2];

    always_comb begin
        rise          = modeBtn & ~btn_prev_reg;
        xfer          = (state_reg == IDLE) & wrValid;
        // A write in the same cycle wins; the toggle stays pending so the
        // write always lands against the mode it was issued under.
        tgl           = (rise | pend_tgl_reg) & (state_reg == IDLE) & ~xfer;

        state_next    = state_reg;
        case (state_reg)
            IDLE:    if (wrValid) state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        pend_tgl_next = pend_tgl_reg;
        if (tgl) begin
            pend_tgl_next = 1'b0;
        end else if (rise) begin
            pend_tgl_next = 1'b1;
        end

        dif_mod_next  = dif_mod_reg ^ tgl;
        mod_chg_next  = tgl;
        wr_ready_next = (state_next == IDLE);
        wr_done_next  = (state_next == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            // Starting high means a button held through reset is not an edge.
            btn_prev_reg <= 1'b1;
            pend_tgl_reg <= 1'b0;
            dif_mod_reg  <= 1'b0;
            mod_chg_reg  <= 1'b0;
            wr_ready_reg <= 1'b1;
            wr_done_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            btn_prev_reg <= modeBtn;
            pend_tgl_reg <= pend_tgl_next;
            dif_mod_reg  <= dif_mod_next;
            mod_chg_reg  <= mod_chg_next;
            wr_ready_reg <= wr_ready_next;
            wr_done_reg  <= wr_done_next;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_mode
        localparam logic [WIDTH-1:0] INIT_VAL = (gi == 0) ? INIT1 : INIT2;
        localparam logic             SEL      = (gi != 0);

        logic [WIDTH-1:0] val_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                val_reg <= INIT_VAL;
            end else if (xfer && (dif_mod_reg == SEL)) begin
                val_reg <= dataIn;
            end
        end

        assign mod_q[gi] = val_reg;
    end

    assign wrReady = wr_ready_reg;
    assign wrDone  = wr_done_reg;
    assign modeChg = mod_chg_reg;
    assign difMod  = dif_mod_reg;
    assign Mod1    = mod_q[0];
    assign Mod2    = mod_q[1];

endmodule
